// File: rtl/mips_run_monitor_pkg.sv
// mips_run_pkg: stop-reason codes and controller states for mips_run_monitor
package mips_run_pkg;
  localparam logic [1:0] STOP_END_PC  = 2'd0;
  localparam logic [1:0] STOP_BP      = 2'd1;
  localparam logic [1:0] STOP_STALL   = 2'd2;
  localparam logic [1:0] STOP_TIMEOUT = 2'd3;
  typedef enum logic [2:0] {HOLD, RUN, DRAIN, DUMP_RD, DUMP_OUT, DONE} state_t;
endpackage

// File: rtl/mips_run_monitor_if.sv
// mips_run_monitor_if: data-memory read port and dump stream of the run monitor
interface mips_run_monitor_if;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] dump_data;
  logic        dump_valid;
  logic        dump_ready;
  logic        dump_last;
  modport master (output mem_rd_en, mem_addr, dump_data, dump_valid, dump_last,
                  input mem_rdata, dump_ready);
  modport slave  (input mem_rd_en, mem_addr, dump_data, dump_valid, dump_last,
                  output mem_rdata, dump_ready);
endinterface

// File: rtl/mips_run_monitor_bp_match.sv
// mips_bp_match: breakpoint comparators with lowest-channel-wins priority encoder
module mips_bp_match #(
  parameter int NUM_BP = 4,
  parameter int BPW    = 2
) (
  input  logic [31:0]          pc,
  input  logic [32*NUM_BP-1:0] bp_addr,
  input  logic [NUM_BP-1:0]    bp_en,
  output logic                 hit,
  output logic [BPW-1:0]       id
);
  always_comb begin
    hit = 1'b0;
    id  = '0;
    for (int k = NUM_BP - 1; k >= 0; k--)
      if (bp_en[k] && bp_addr[32*k +: 32] == pc) begin
        hit = 1'b1;
        id  = BPW'(k);
      end
  end
endmodule

// File: rtl/mips_run_monitor.sv
// mips_run_monitor: core run controller and data-memory dumper; MIPS_RUN_MONITOR_STALL_DETECT_EN adds the PC-stall stop
module mips_run_monitor
  import mips_run_pkg::*;
#(
  parameter int          NUM_BP       = 4,
  parameter logic [31:0] END_PC       = 32'h84,
  parameter int          HOLD_CYCLES  = 3,
  parameter int          DRAIN_CYCLES = 5,
  parameter int          DUMP_BASE    = 32,
  parameter int          DUMP_WORDS   = 96,
  parameter int          MAX_CYCLES   = 50000,
  parameter int          STALL_LIMIT  = 16,
  localparam int         BPW          = NUM_BP > 1 ? $clog2(NUM_BP) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   core_reset_n,
  input  logic [31:0]            pc,
  input  logic [32*NUM_BP-1:0]   bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  mips_run_monitor_if.master     bus,
  output logic                   done,
  output logic [1:0]             stop_reason,
  output logic [BPW-1:0]         bp_id,
  output logic [31:0]            cycle_count
);
  state_t         state, state_nx;
  logic [31:0]    pc_q, cnt, idx, dump_data;
  logic           dump_valid, dump_last;
  logic           bp_hit, stall_hit, timeout_hit, stop;
  logic [BPW-1:0] bp_hit_id;
  logic [1:0]     reason_nx;

  mips_bp_match #(.NUM_BP(NUM_BP), .BPW(BPW)) u_bp (
    .pc(pc_q), .bp_addr(bp_addr), .bp_en(bp_en), .hit(bp_hit), .id(bp_hit_id)
  );

`ifdef MIPS_RUN_MONITOR_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [31:0] pc_prev;
  logic [SW-1:0] stall_cnt;
  always_ff @(posedge clk)
    if (!reset) begin
      pc_prev   <= '0;
      stall_cnt <= '0;
    end else begin
      pc_prev   <= pc_q;
      stall_cnt <= (state == RUN && pc_q == pc_prev) ? stall_cnt + 1'b1 : '0;
    end
  assign stall_hit = state == RUN && pc_q == pc_prev && stall_cnt == SW'(STALL_LIMIT - 1);
`else
  assign stall_hit = 1'b0;
`endif

  assign timeout_hit = cycle_count == 32'(MAX_CYCLES - 1);
  assign stop        = bp_hit || pc_q == END_PC || stall_hit || timeout_hit;
  assign reason_nx   = bp_hit ? STOP_BP : pc_q == END_PC ? STOP_END_PC : stall_hit ? STOP_STALL : STOP_TIMEOUT;

  always_ff @(posedge clk) state <= !reset ? HOLD : state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      HOLD:     state_nx = (cnt == 32'(HOLD_CYCLES - 1)) ? RUN : HOLD;
      RUN:      state_nx = stop ? DRAIN : RUN;
      DRAIN:    state_nx = (cnt == 32'(DRAIN_CYCLES - 1)) ? DUMP_RD : DRAIN;
      DUMP_RD:  state_nx = DUMP_OUT;
      DUMP_OUT: state_nx = (dump_valid && bus.dump_ready) ? (dump_last ? DONE : DUMP_RD) : DUMP_OUT;
      default:  state_nx = DONE;
    endcase
  end

  // The first DUMP_OUT cycle only captures the read data, so dump_valid never races the memory latency.
  always_ff @(posedge clk)
    if (!reset) begin
      pc_q        <= '0;
      cnt         <= '0;
      idx         <= '0;
      dump_data   <= '0;
      dump_valid  <= 1'b0;
      dump_last   <= 1'b0;
      stop_reason <= '0;
      bp_id       <= '0;
      cycle_count <= '0;
    end else begin
      pc_q <= pc;
      cnt  <= (state_nx != state) ? '0 : cnt + 32'd1;
      if (state == RUN) begin
        cycle_count <= &cycle_count ? cycle_count : cycle_count + 32'd1;
        if (stop) begin
          stop_reason <= reason_nx;
          bp_id       <= bp_hit_id;
        end
      end
      if (state == DRAIN) idx <= '0;
      if (state == DUMP_OUT) begin
        if (!dump_valid) begin
          dump_data  <= bus.mem_rdata;
          dump_valid <= 1'b1;
          dump_last  <= idx == 32'(DUMP_WORDS - 1);
        end else if (bus.dump_ready) begin
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          idx        <= idx + 32'd1;
        end
      end
    end

  assign core_reset_n   = state != HOLD;
  assign done           = state == DONE;
  assign bus.mem_rd_en  = state == DUMP_RD;
  assign bus.mem_addr   = (state == DUMP_RD) ? 32'(DUMP_BASE) + idx : '0;
  assign bus.dump_data  = dump_data;
  assign bus.dump_valid = dump_valid;
  assign bus.dump_last  = dump_last;
endmodule
